// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes an RV32I instruction into an ALU select code and
// operands, presented from a registered output stage with valid/ready flow control.
module alu_issue_stage #(
    parameter int         CNT_W       = 16,
    parameter logic [3:0] ILLEGAL_SEL = 4'b0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_rs1_data,
    input  logic [31:0]      in_rs2_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_alu_sel,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic             out_invert,
    output logic             out_is_mem,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;
    localparam logic [3:0] SEL_SEQ = 4'b1111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic        accept;

    logic [3:0]  dec_sel;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic        dec_invert;
    logic        dec_is_mem;
    logic        dec_illegal;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        dec_sel     = ILLEGAL_SEL;
        dec_a       = in_rs1_data;
        dec_b       = in_rs2_data;
        dec_invert  = 1'b0;
        dec_is_mem  = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            OP_R: begin
                case ({funct7, funct3})
                    {7'h00, 3'b000}: dec_sel = SEL_ADD;
                    {7'h20, 3'b000}: dec_sel = SEL_SUB;
                    {7'h00, 3'b111}: dec_sel = SEL_AND;
                    {7'h00, 3'b110}: dec_sel = SEL_OR;
                    {7'h00, 3'b010}: dec_sel = SEL_SLT;
                    default:         dec_illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                dec_b = imm_i;
                case (funct3)
                    3'b000:  dec_sel = SEL_ADD;
                    3'b111:  dec_sel = SEL_AND;
                    3'b110:  dec_sel = SEL_OR;
                    3'b010:  dec_sel = SEL_SLT;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                dec_sel    = SEL_ADD;
                dec_b      = imm_i;
                dec_is_mem = 1'b1;
            end
            OP_STORE: begin
                dec_sel    = SEL_ADD;
                dec_b      = imm_s;
                dec_is_mem = 1'b1;
            end
            OP_BRANCH: begin
                // Only SEQ/SLT exist in the ALU; NE and GE come from inverting their result.
                case (funct3)
                    3'b000:  dec_sel = SEL_SEQ;
                    3'b001: begin dec_sel = SEL_SEQ; dec_invert = 1'b1; end
                    3'b100:  dec_sel = SEL_SLT;
                    3'b101: begin dec_sel = SEL_SLT; dec_invert = 1'b1; end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_sel    = ILLEGAL_SEL;
            dec_a      = '0;
            dec_b      = '0;
            dec_invert = 1'b0;
            dec_is_mem = 1'b0;
        end
    end

    // Flush wins over accept so a redirected instruction never reaches the ALU or the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_alu_sel <= 4'b0000;
            out_a       <= '0;
            out_b       <= '0;
            out_invert  <= 1'b0;
            out_is_mem  <= 1'b0;
            out_illegal <= 1'b0;
            illegal_cnt <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_alu_sel <= dec_sel;
            out_a       <= dec_a;
            out_b       <= dec_b;
            out_invert  <= dec_invert;
            out_is_mem  <= dec_is_mem;
            out_illegal <= dec_illegal;
            if (dec_illegal && (illegal_cnt != {CNT_W{1'b1}}))
                illegal_cnt <= illegal_cnt + CNT_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed scenarios followed by randomized traffic,
// all checked against an instruction-level reference model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        flush;
    logic        out_ready;

    logic        in_ready, out_valid, out_invert, out_is_mem, out_illegal;
    logic [3:0]  out_alu_sel;
    logic [31:0] out_a, out_b;
    logic [15:0] illegal_cnt;

    logic        in_ready2, out_valid2, out_invert2, out_is_mem2, out_illegal2;
    logic [3:0]  out_alu_sel2;
    logic [31:0] out_a2, out_b2;
    logic [1:0]  illegal_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.CNT_W(16), .ILLEGAL_SEL(4'b0000)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_sel(out_alu_sel), .out_a(out_a), .out_b(out_b),
        .out_invert(out_invert), .out_is_mem(out_is_mem), .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    alu_issue_stage #(.CNT_W(2), .ILLEGAL_SEL(4'b0000)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_instr(in_instr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
        .out_alu_sel(out_alu_sel2), .out_a(out_a2), .out_b(out_b2),
        .out_invert(out_invert2), .out_is_mem(out_is_mem2), .out_illegal(out_illegal2),
        .illegal_cnt(illegal_cnt2)
    );

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic        inv;
        logic        mem;
        logic        ill;
    } entry_t;

    entry_t      m_ent;
    bit          m_valid;
    int unsigned m_cnt16;
    int unsigned m_cnt2;

    // Reference decode written straight from the instruction-set rules.
    function automatic entry_t ref_decode(logic [31:0] ins, logic [31:0] rs1, logic [31:0] rs2);
        entry_t e;
        int imm_i;
        int imm_s;
        int op;
        int f3;
        int f7;
        op    = int'(ins[6:0]);
        f3    = int'(ins[14:12]);
        f7    = int'(ins[31:25]);
        imm_i = $signed(ins) >>> 20;
        imm_s = (($signed(ins) >>> 25) * 32) + int'(ins[11:7]);
        e = '{sel: 4'd0, a: rs1, b: rs2, inv: 1'b0, mem: 1'b0, ill: 1'b0};
        if (op == 'h33) begin
            if (f3 == 0 && f7 == 0)         e.sel = 4'b0010;
            else if (f3 == 0 && f7 == 'h20) e.sel = 4'b0110;
            else if (f3 == 7 && f7 == 0)    e.sel = 4'b0000;
            else if (f3 == 6 && f7 == 0)    e.sel = 4'b0001;
            else if (f3 == 2 && f7 == 0)    e.sel = 4'b0111;
            else                            e.ill = 1'b1;
        end else if (op == 'h13) begin
            e.b = 32'(imm_i);
            if (f3 == 0)      e.sel = 4'b0010;
            else if (f3 == 7) e.sel = 4'b0000;
            else if (f3 == 6) e.sel = 4'b0001;
            else if (f3 == 2) e.sel = 4'b0111;
            else              e.ill = 1'b1;
        end else if (op == 'h03) begin
            e.sel = 4'b0010; e.b = 32'(imm_i); e.mem = 1'b1;
        end else if (op == 'h23) begin
            e.sel = 4'b0010; e.b = 32'(imm_s); e.mem = 1'b1;
        end else if (op == 'h63) begin
            if (f3 == 0 || f3 == 1)      e.sel = 4'b1111;
            else if (f3 == 4 || f3 == 5) e.sel = 4'b0111;
            else                         e.ill = 1'b1;
            e.inv = (f3 == 1 || f3 == 5);
        end else begin
            e.ill = 1'b1;
        end
        if (e.ill) e = '{sel: 4'd0, a: 32'd0, b: 32'd0, inv: 1'b0, mem: 1'b0, ill: 1'b1};
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(bit r, bit v, logic [31:0] ins, logic [31:0] rs1,
                                 logic [31:0] rs2, bit rdy, bit fl);
        rst = r; in_valid = v; in_instr = ins; in_rs1_data = rs1;
        in_rs2_data = rs2; out_ready = rdy; flush = fl;
    endtask

    task automatic checkOutput();
        chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
        chk("in_ready_small", 32'(in_ready2), 32'(!m_valid || out_ready));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_alu_sel", 32'(out_alu_sel), 32'(m_ent.sel));
        chk("out_a", out_a, m_ent.a);
        chk("out_b", out_b, m_ent.b);
        chk("out_invert", 32'(out_invert), 32'(m_ent.inv));
        chk("out_is_mem", 32'(out_is_mem), 32'(m_ent.mem));
        chk("out_illegal", 32'(out_illegal), 32'(m_ent.ill));
        chk("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt16));
        chk("illegal_cnt_small", 32'(illegal_cnt2), 32'(m_cnt2));
    endtask

    // One clock: drive at the falling edge, compare against the model, then
    // advance the model with the rising edge that samples these inputs.
    task automatic step(bit r, bit v, logic [31:0] ins, logic [31:0] rs1,
                        logic [31:0] rs2, bit rdy, bit fl);
        bit take;
        entry_t d;
        @(negedge clk);
        applyStimulus(r, v, ins, rs1, rs2, rdy, fl);
        #1;
        checkOutput();
        @(posedge clk);
        take = v && (!m_valid || rdy);
        if (r) begin
            m_valid = 0;
            m_ent   = '{sel: 4'd0, a: 32'd0, b: 32'd0, inv: 1'b0, mem: 1'b0, ill: 1'b0};
            m_cnt16 = 0;
            m_cnt2  = 0;
        end else if (fl) begin
            m_valid = 0;
        end else if (take) begin
            d       = ref_decode(ins, rs1, rs2);
            m_ent   = d;
            m_valid = 1;
            if (d.ill && m_cnt16 < 65535) m_cnt16++;
            if (d.ill && m_cnt2 < 3)      m_cnt2++;
        end else if (rdy) begin
            m_valid = 0;
        end
        #2;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int kind;
        ins  = $urandom;
        kind = $urandom_range(0, 7);
        case (kind)
            0: begin
                ins[6:0] = 7'h33;
                case ($urandom_range(0, 2))
                    0:       ins[31:25] = 7'h00;
                    1:       ins[31:25] = 7'h20;
                    default: ins[31:25] = 7'($urandom);
                endcase
            end
            1: ins[6:0] = 7'h13;
            2: ins[6:0] = 7'h03;
            3: ins[6:0] = 7'h23;
            4, 5: ins[6:0] = 7'h63;
            default: ins = ins;
        endcase
        return ins;
    endfunction

    initial begin
        m_valid = 0; m_cnt16 = 0; m_cnt2 = 0;
        m_ent = '{sel: 4'd0, a: 32'd0, b: 32'd0, inv: 1'b0, mem: 1'b0, ill: 1'b0};
        applyStimulus(1, 0, 0, 0, 0, 0, 0);

        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_cnt", 32'(illegal_cnt), 32'd0);

        step(0, 1, 32'h00208033, 5, 7, 1, 0);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_sel", 32'(out_alu_sel), 32'b0010);
        chk("add_a", out_a, 32'd5);
        chk("add_b", out_b, 32'd7);
        chk("add_illegal", 32'(out_illegal), 32'd0);

        step(0, 1, 32'h40208033, 0, 9, 1, 0);
        chk("sub_sel", 32'(out_alu_sel), 32'b0110);
        step(0, 1, 32'hFFF00093, 0, 9, 1, 0);
        chk("addi_sel", 32'(out_alu_sel), 32'b0010);
        chk("addi_b", out_b, 32'hFFFFFFFF);
        step(0, 0, 0, 0, 0, 1, 0);

        step(0, 1, 32'h0020A223, 32'h100, 32'h55, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("sw_stall_ready", 32'(in_ready), 32'd0);
            chk("sw_a", out_a, 32'h100);
            chk("sw_b", out_b, 32'd4);
            chk("sw_mem", 32'(out_is_mem), 32'd1);
            step(0, 1, 32'h00208033, 1, 2, (i == 2), 0);
        end
        step(0, 0, 0, 0, 0, 1, 0);

        step(0, 1, 32'h00209063, 3, 3, 1, 0);
        chk("bne_sel", 32'(out_alu_sel), 32'b1111);
        chk("bne_invert", 32'(out_invert), 32'd1);
        chk("bne_a", out_a, 32'd3);

        step(0, 1, 32'hFFFFFFFF, 1, 2, 1, 0);
        step(0, 1, 32'hFFFFFFFF, 1, 2, 1, 0);
        chk("ill_flag", 32'(out_illegal), 32'd1);
        chk("ill_sel", 32'(out_alu_sel), 32'b0000);
        chk("ill_cnt_two", 32'(illegal_cnt), 32'd2);
        step(0, 1, 32'hFFFFFFFF, 1, 2, 1, 1);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_cnt", 32'(illegal_cnt), 32'd2);

        for (int i = 0; i < 5; i++) step(0, 1, 32'h0000007F, 0, 0, 1, 0);
        chk("sat_small", 32'(illegal_cnt2), 32'd3);
        chk("cnt_big", 32'(illegal_cnt), 32'd7);

        step(0, 1, 32'h00208033, 5, 7, 0, 0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_a", out_a, 32'd0);
        chk("rst_sel", 32'(out_alu_sel), 32'd0);
        chk("rst_cnt", 32'(illegal_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0),
                 rand_instr(), $urandom, $urandom,
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 11) == 0));
        end
        step(0, 0, 0, 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
